half_adder: RTL and testbench

- Parameterised bank of WIDTH independent one-bit half adders.
- Per lane: sum = a XOR b, carry = a AND b.
- Combinational outputs are available immediately. A registered copy with a valid flag is also provided for pipelined consumers.
- A saturating carry-event counter supports debug and observation.
- Leaf arithmetic block; sits directly under datapath or test harnesses.

---
 rtl/half_adder_pkg.sv | 21 ++
 rtl/half_adder_if.sv | 36 +++
 rtl/half_adder_lane.sv | 23 ++
 rtl/half_adder.sv | 84 ++++++++
 tb/tb_half_adder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/half_adder_pkg.sv
// Shared constants, payload type and single-bit helper for the half-adder bank.
package half_adder_pkg;

    localparam int unsigned HA_WIDTH_DEF = 1;
    localparam int unsigned HA_CNT_W_DEF = 16;

    // One lane's result, carry in the MSB so the packed value reads {carry,sum}.
    typedef struct packed {
        logic carry;
        logic sum;
    } ha_bit_t;

    // Single-bit half add.
    function automatic ha_bit_t ha_bit(input logic a, input logic b);
        ha_bit_t r;
        r.carry = a & b;
        r.sum   = a ^ b;
        return r;
    endfunction

endpackage : half_adder_pkg

// File: rtl/half_adder_if.sv
// Bus bundle for the half-adder bank.
//   master : drives a, b, in_valid, cnt_clr; observes all results
//   slave  : the adder bank itself
//   a, b      : lane operands
//   in_valid  : qualifies a/b for the registered path and the counter
//   cnt_clr   : synchronous clear of carry_cnt
//   sum/carry : combinational per-lane results
//   sum_q/carry_q/out_valid : registered results, one cycle later
//   carry_cnt : saturating count of valid cycles with any carry lane set
interface half_adder_if #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             cnt_clr;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             out_valid;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output a, b, in_valid, cnt_clr,
        input  sum, carry, sum_q, carry_q, out_valid, carry_cnt
    );

    modport slave (
        input  a, b, in_valid, cnt_clr,
        output sum, carry, sum_q, carry_q, out_valid, carry_cnt
    );

endinterface : half_adder_if

// File: rtl/half_adder_lane.sv
// One combinational half-adder lane.
//   a, b  : operand bits
//   sum   : a XOR b
//   carry : a AND b
module half_adder_lane
    import half_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    ha_bit_t res;

    always_comb begin
        res = ha_bit(a, b);
    end

    assign sum   = res.sum;
    assign carry = res.carry;

endmodule : half_adder_lane

// File: rtl/half_adder.sv
// Bank of WIDTH independent half adders with a registered copy of the
// result, a valid flag, and a saturating carry-event counter.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : half_adder_if slave (operands, results, counter, clear)
module half_adder
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH = HA_WIDTH_DEF,
    parameter int unsigned CNT_W = HA_CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    half_adder_if.slave bus
);

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;
    logic             carry_any_c;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_d;
    logic [WIDTH-1:0] carry_q;
    logic             valid_d;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Independent lanes; no carry ripples between them.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
        half_adder_lane u_lane (
            .a     (bus.a[i]),
            .b     (bus.b[i]),
            .sum   (sum_c[i]),
            .carry (carry_c[i])
        );
    end

    assign carry_any_c = |carry_c;

    // Next-state for result capture, valid pipe and counter.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = bus.in_valid;
        cnt_d   = cnt_q;

        if (bus.in_valid) begin
            sum_d   = sum_c;
            carry_d = carry_c;
        end

        // Clear wins over a same-cycle increment; the count sticks at all-ones.
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (bus.in_valid && carry_any_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sum       = sum_c;
    assign bus.carry     = carry_c;
    assign bus.sum_q     = sum_q;
    assign bus.carry_q   = carry_q;
    assign bus.out_valid = valid_q;
    assign bus.carry_cnt = cnt_q;

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: a 1-lane instance with a 2-bit counter and a
// 4-lane instance with the default counter width, sharing clock and reset.
module tb_half_adder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    half_adder_if #(.WIDTH(1), .CNT_W(2))  if1 ();
    half_adder_if #(.WIDTH(4), .CNT_W(16)) if4 ();

    half_adder #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    half_adder #(.WIDTH(4), .CNT_W(16)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        if1.a = 1'b0; if1.b = 1'b0; if1.in_valid = 1'b0; if1.cnt_clr = 1'b0;
        if4.a = 4'h0; if4.b = 4'h0; if4.in_valid = 1'b0; if4.cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if1.sum_q !== 1'b0) begin
            failures++; $display("FAIL reset_sum_q got=%0h exp=0", if1.sum_q);
        end
        checks++;
        if (if1.carry_q !== 1'b0) begin
            failures++; $display("FAIL reset_carry_q got=%0h exp=0", if1.carry_q);
        end
        checks++;
        if (if1.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%0h exp=0", if1.out_valid);
        end
        checks++;
        if (if1.carry_cnt !== 2'd0) begin
            failures++; $display("FAIL reset_carry_cnt got=%0h exp=0", if1.carry_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_comb_exhaustive();
        logic [1:0] av [4] = '{2'b0, 2'b0, 2'b1, 2'b1};
        logic [1:0] bv [4] = '{2'b0, 2'b1, 2'b0, 2'b1};
        logic       es [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       ec [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            if1.a = av[i][0];
            if1.b = bv[i][0];
            #20;
            checks++;
            if (if1.sum !== es[i]) begin
                failures++;
                $display("FAIL comb_sum a=%0b b=%0b got=%0b exp=%0b", av[i][0], bv[i][0], if1.sum, es[i]);
            end
            checks++;
            if (if1.carry !== ec[i]) begin
                failures++;
                $display("FAIL comb_carry a=%0b b=%0b got=%0b exp=%0b", av[i][0], bv[i][0], if1.carry, ec[i]);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (if1.sum_q !== 1'b0) begin
            failures++; $display("FAIL reg_sum_q got=%0b exp=0", if1.sum_q);
        end
        checks++;
        if (if1.carry_q !== 1'b1) begin
            failures++; $display("FAIL reg_carry_q got=%0b exp=1", if1.carry_q);
        end
        checks++;
        if (if1.out_valid !== 1'b1) begin
            failures++; $display("FAIL reg_out_valid got=%0b exp=1", if1.out_valid);
        end
        @(negedge clk);
        if1.in_valid = 1'b0; if1.a = 1'b0; if1.b = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (if1.out_valid !== 1'b0) begin
            failures++; $display("FAIL hold_out_valid got=%0b exp=0", if1.out_valid);
        end
        checks++;
        if (if1.sum_q !== 1'b0) begin
            failures++; $display("FAIL hold_sum_q got=%0b exp=0", if1.sum_q);
        end
        checks++;
        if (if1.carry_q !== 1'b1) begin
            failures++; $display("FAIL hold_carry_q got=%0b exp=1", if1.carry_q);
        end
        checks++;
        if (if1.carry_cnt !== 2'd1) begin
            failures++; $display("FAIL reg_carry_cnt got=%0d exp=1", if1.carry_cnt);
        end
    endtask

    task automatic test_multilane();
        logic [3:0] av [3] = '{4'b1100, 4'b1111, 4'b0101};
        logic [3:0] bv [3] = '{4'b1010, 4'b0001, 4'b0101};
        logic [3:0] es [3] = '{4'b0110, 4'b1110, 4'b0000};
        logic [3:0] ec [3] = '{4'b1000, 4'b0001, 4'b0101};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if4.a = av[i]; if4.b = bv[i]; if4.in_valid = 1'b1;
            #1;
            checks++;
            if (if4.sum !== es[i]) begin
                failures++; $display("FAIL lanes_sum got=%b exp=%b", if4.sum, es[i]);
            end
            checks++;
            if (if4.carry !== ec[i]) begin
                failures++; $display("FAIL lanes_carry got=%b exp=%b", if4.carry, ec[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({if4.carry_q, if4.sum_q} !== {ec[i], es[i]}) begin
                failures++;
                $display("FAIL lanes_reg got=%b_%b exp=%b_%b", if4.carry_q, if4.sum_q, ec[i], es[i]);
            end
        end
        // Three valid cycles, each with at least one carry lane.
        checks++;
        if (if4.carry_cnt !== 16'd3) begin
            failures++; $display("FAIL lanes_carry_cnt got=%0d exp=3", if4.carry_cnt);
        end
        @(negedge clk);
        if4.in_valid = 1'b0;
    endtask

    task automatic test_counter();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        @(negedge clk);
        if1.cnt_clr = 1'b1; if1.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (if1.carry_cnt !== 2'd0) begin
            failures++; $display("FAIL cnt_clear got=%0d exp=0", if1.carry_cnt);
        end
        @(negedge clk);
        if1.cnt_clr = 1'b0; if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (if1.carry_cnt !== exp_cnt[i]) begin
                failures++; $display("FAIL cnt_step%0d got=%0d exp=%0d", i, if1.carry_cnt, exp_cnt[i]);
            end
        end
        @(negedge clk);
        if1.cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (if1.carry_cnt !== 2'd0) begin
            failures++; $display("FAIL cnt_clr_priority got=%0d exp=0", if1.carry_cnt);
        end
        @(negedge clk);
        if1.cnt_clr = 1'b0; if1.a = 1'b1; if1.b = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (if1.carry_cnt !== 2'd0) begin
            failures++; $display("FAIL cnt_no_carry got=%0d exp=0", if1.carry_cnt);
        end
        @(negedge clk);
        if1.b = 1'b1; if1.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (if1.carry_cnt !== 2'd0) begin
            failures++; $display("FAIL cnt_not_valid got=%0d exp=0", if1.carry_cnt);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (if1.out_valid !== 1'b1 || if1.carry_cnt !== 2'd1) begin
            failures++;
            $display("FAIL arst_pre got=v%0b c%0d exp=v1 c1", if1.out_valid, if1.carry_cnt);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (if1.out_valid !== 1'b0) begin
            failures++; $display("FAIL arst_out_valid got=%0b exp=0", if1.out_valid);
        end
        checks++;
        if (if1.carry_q !== 1'b0 || if1.sum_q !== 1'b0) begin
            failures++; $display("FAIL arst_regs got=%0b%0b exp=00", if1.carry_q, if1.sum_q);
        end
        checks++;
        if (if1.carry_cnt !== 2'd0) begin
            failures++; $display("FAIL arst_carry_cnt got=%0d exp=0", if1.carry_cnt);
        end
        if1.a = 1'b0; if1.b = 1'b1;
        #1;
        checks++;
        if (if1.sum !== 1'b1 || if1.carry !== 1'b0) begin
            failures++; $display("FAIL arst_comb got=s%0b c%0b exp=s1 c0", if1.sum, if1.carry);
        end
        @(posedge clk);
        #1;
        checks++;
        if (if1.out_valid !== 1'b0) begin
            failures++; $display("FAIL arst_held got=%0b exp=0", if1.out_valid);
        end
        @(negedge clk);
        rst = 1'b0; if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (if1.out_valid !== 1'b1 || if1.carry_q !== 1'b1 || if1.sum_q !== 1'b0) begin
            failures++;
            $display("FAIL arst_first_valid got=v%0b c%0b s%0b exp=v1 c1 s0", if1.out_valid, if1.carry_q, if1.sum_q);
        end
        @(negedge clk);
        if1.in_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_comb_exhaustive();
        test_registered();
        test_multilane();
        test_counter();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_half_adder
